// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSB first, start/busy/done handshake.
// Optional build macro ADDSUB_SAT_EN clamps the result to the signed limits on overflow.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("addsub_serial: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic             carry, op_q, a_msb, b_msb;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] acc_next, res_final;
    logic             last, accept, ovf_next, cout_next;

`ifdef ADDSUB_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] sum,
                                                  input logic             ovfl,
                                                  input logic             neg);
        if (ovfl)
            return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return sum;
    endfunction
`endif

    assign accept = (state_q == IDLE) && start;
    assign last   = (cnt == CNT_W'(NDIG - 1));

    // Digit adder: low DIGIT bits of both operands plus the running carry
    assign dsum      = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign acc_next  = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);
    assign ovf_next  = (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
    assign cout_next = op_q ? ~dsum[DIGIT] : dsum[DIGIT];

`ifdef ADDSUB_SAT_EN
    assign res_final = saturate(acc_next, ovf_next, a_msb);
`else
    assign res_final = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (accept)
            cnt <= '0;
        else if (state_q == BUSY)
            cnt <= cnt + 1'b1;
    end

    // Operand shifters and accumulator; only control and visible outputs are reset
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh  <= a;
            b_sh  <= op ? ~b : b;
            carry <= op;
            op_q  <= op;
            a_msb <= a[WIDTH-1];
            b_msb <= op ? ~b[WIDTH-1] : b[WIDTH-1];
            acc   <= '0;
        end else if (state_q == BUSY) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            carry <= dsum[DIGIT];
            acc   <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
        end else if (state_q == BUSY && last) begin
            result <= res_final;
            cout   <= cout_next;
            ovf    <= ovf_next;
            zero   <= (res_final == '0);
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=8, DIGIT=2): directed cases plus random back-to-back ops.
module tb_addsub_serial;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int NDIG = W / D;

    logic         clk = 1'b0;
    logic         rst, start, op;
    logic [W-1:0] a, b, result;
    logic         cout, ovf, zero, busy, done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] held_r;
    logic         held_c, held_v, held_z;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop,
                                  output logic [W-1:0] r, output logic c, output logic v,
                                  output logic z);
        longint ua, ub, sa, sb, ur, sr, lim;
        ua  = longint'(ma);
        ub  = longint'(mb);
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        ur  = mop ? ua - ub : ua + ub;
        sr  = mop ? sa - sb : sa + sb;
        lim = longint'(1) << (W - 1);
        c   = mop ? (ua < ub) : (ur >= (longint'(1) << W));
        v   = (sr >= lim) || (sr < -lim);
        r   = W'(ur);
`ifdef ADDSUB_SAT_EN
        if (v) r = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        z   = (r == '0);
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic top);
        logic [W-1:0] er;
        logic         ec, ev, ez;
        int           n;
        model(ta, tbv, top, er, ec, ev, ez);
        start = 1'b1; a = ta; b = tbv; op = top;
        tick;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        n = 0;
        while (done !== 1'b1 && n < 4 * NDIG + 8) begin
            chk("result_held_busy", result, held_r);
            tick;
            n++;
        end
        chk("latency", n, NDIG);
        chk("result", result, er);
        chk("cout", cout, ec);
        chk("ovf", ovf, ev);
        chk("zero", zero, ez);
        chk("busy_in_done", busy, 1);
        held_r = er; held_c = ec; held_v = ev; held_z = ez;
        tick;
        chk("done_one_cycle", done, 0);
        chk("busy_back_idle", busy, 0);
        chk("result_held_idle", result, held_r);
    endtask

    initial begin
        int n, dones;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 1);
        held_r = '0; held_c = 1'b0; held_v = 1'b0; held_z = 1'b1;

        run_op(8'h05, 8'h03, 1'b1);
        chk("t1_const_result", result, 8'h02);
        run_op(8'h03, 8'h05, 1'b1);
        chk("t2a_const_result", result, 8'hFE);
        chk("t2a_const_cout", cout, 1);
        run_op(8'h80, 8'h01, 1'b1);
        chk("t2b_const_ovf", ovf, 1);
        chk("t2b_const_cout", cout, 0);
`ifdef ADDSUB_SAT_EN
        chk("t2b_const_result", result, 8'h80);
`else
        chk("t2b_const_result", result, 8'h7F);
`endif
        run_op(8'h7F, 8'h01, 1'b0);
        chk("t3a_const_ovf", ovf, 1);
`ifdef ADDSUB_SAT_EN
        chk("t3a_const_result", result, 8'h7F);
`else
        chk("t3a_const_result", result, 8'h80);
`endif
        run_op(8'hFF, 8'h01, 1'b0);
        chk("t3b_const_result", result, 8'h00);
        chk("t3b_const_cout", cout, 1);
        chk("t3b_const_zero", zero, 1);
        chk("t3b_const_ovf", ovf, 0);

        // start held high through BUSY and DONE with different operands
        start = 1'b1; a = 8'h10; b = 8'h20; op = 1'b0;
        tick;
        a = 8'h55; b = 8'h11; op = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 4 * NDIG + 8) begin
            tick;
            n++;
        end
        chk("t4_latency", n, NDIG);
        chk("t4_result", result, 8'h30);
        tick;
        start = 1'b0;
        chk("t4_start_in_done_ignored", busy, 0);
        dones = 0;
        for (int i = 0; i < NDIG + 3; i++) begin
            tick;
            if (done === 1'b1) dones++;
        end
        chk("t4_single_done", dones, 0);
        chk("t4_result_kept", result, 8'h30);
        held_r = 8'h30; held_c = 1'b0; held_v = 1'b0; held_z = 1'b0;

        // reset in the second BUSY cycle
        start = 1'b1; a = 8'h12; b = 8'h34; op = 1'b0;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_result", result, 0);
        chk("t5_zero", zero, 1);
        held_r = '0; held_c = 1'b0; held_v = 1'b0; held_z = 1'b1;
        dones = 0;
        for (int i = 0; i < NDIG + 2; i++) begin
            tick;
            if (done === 1'b1) dones++;
        end
        chk("t5_no_done", dones, 0);
        run_op(8'h12, 8'h34, 1'b0);
        chk("t5_after_rst_result", result, 8'h46);

        for (int i = 0; i < 200; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
